// File: rtl/lsu_mem_adapter.sv
// Byte-addressed load/store to word-memory adapter; sub-word stores via read-modify-write. Optional misalignment trap: LSU_MISALIGN_TRAP_EN.
// Latency from accept: error 1, load/word store 2, sub-word store 3 cycles.
// Backpressure: req_ready only in IDLE; response is a single-cycle pulse with no backpressure.
module lsu_mem_adapter #(
  parameter int ADDR_WORD_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WRITE  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;

  state_t                    state_q, state_d;
  logic [ADDR_WORD_BITS-1:0] waddr_q, waddr_d;
  logic [1:0]                lane_q, lane_d;
  logic [1:0]                size_q, size_d;
  logic                      we_q, we_d;
  logic                      uns_q, uns_d;
  logic [31:0]               wr_word_q, wr_word_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      err_q, err_d;

  logic [1:0]  req_lane;
  logic        req_err;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] merged;

  // Address bits above the word index alias onto the same memory word.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_WORD_BITS+2];

  always_comb begin
    req_lane = req_addr[1:0];
    case (req_size)
      SZ_H:    req_lane = {req_addr[1], 1'b0};
      SZ_W:    req_lane = 2'b00;
      default: req_lane = req_addr[1:0];
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_err = (req_size == SZ_RSV) ||
                   ((req_size == SZ_H) && req_addr[0]) ||
                   ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
`else
  assign req_err = (req_size == SZ_RSV);
`endif

  assign ld_byte = mem_rd_data[{lane_q, 3'b000} +: 8];
  assign ld_half = mem_rd_data[{lane_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = mem_rd_data;
    merged  = mem_rd_data;
    case (size_q)
      SZ_B: begin
        ld_data = {{24{~uns_q & ld_byte[7]}}, ld_byte};
        merged[{lane_q, 3'b000} +: 8] = wr_word_q[7:0];
      end
      SZ_H: begin
        ld_data = {{16{~uns_q & ld_half[15]}}, ld_half};
        merged[{lane_q[1], 4'b0000} +: 16] = wr_word_q[15:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    waddr_d   = waddr_q;
    lane_d    = lane_q;
    size_d    = size_q;
    we_d      = we_q;
    uns_d     = uns_q;
    wr_word_d = wr_word_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          waddr_d   = req_addr[ADDR_WORD_BITS+1:2];
          lane_d    = req_lane;
          size_d    = req_size;
          we_d      = req_we;
          uns_d     = req_unsigned;
          wr_word_d = req_wdata;
          rdata_d   = '0;
          err_d     = req_err;
          state_d   = req_err ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!we_q) begin
          rdata_d = ld_data;
          state_d = S_RESP;
        end else if (size_q == SZ_W) begin
          state_d = S_RESP;
        end else begin
          // Old word is only valid now; hold the merge for the write cycle.
          wr_word_d = merged;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: state_d = S_RESP;
      S_RESP: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      waddr_q   <= '0;
      lane_q    <= '0;
      size_q    <= '0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      wr_word_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      waddr_q   <= waddr_d;
      lane_q    <= lane_d;
      size_q    <= size_d;
      we_q      <= we_d;
      uns_q     <= uns_d;
      wr_word_q <= wr_word_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign resp_valid  = (state_q == S_RESP);
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;
  assign mem_addr    = {{(32-ADDR_WORD_BITS){1'b0}}, waddr_q};
  assign mem_wr_data = wr_word_q;
  // Decoded from state so a reset mid-RMW kills the strobe immediately.
  assign mem_wr_en   = ((state_q == S_ACCESS) && we_q && (size_q == SZ_W)) ||
                       (state_q == S_WRITE);

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Randomized and directed bench for lsu_mem_adapter against a byte-level memory model.
module tb_lsu_mem_adapter;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];

  int n_cmp = 0;
  int n_bad = 0;

  lsu_mem_adapter #(.ADDR_WORD_BITS(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_addr[9:0]];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr[9:0]] <= mem_wr_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Byte-level reference: expected response, latency, write count; updates ref_mem.
  task automatic model(input logic we, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err,
                       output int lat, output int nwr);
    int          idx, off, nbytes;
    logic [31:0] mask, v;
    idx = int'(a[11:2]);
    off = int'(a[1:0]);
    err = (sz == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    if (sz == 2'b01 && off % 2 != 0) err = 1'b1;
    if (sz == 2'b10 && off != 0) err = 1'b1;
`else
    if (sz == 2'b01) off = off - off % 2;
    if (sz == 2'b10) off = 0;
`endif
    rd = '0; lat = 1; nwr = 0;
    if (!err) begin
      nbytes = 1 << sz;
      mask = (nbytes == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nbytes)) - 32'd1;
      if (we) begin
        ref_mem[idx] = (ref_mem[idx] & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
        lat = (nbytes == 4) ? 2 : 3;
        nwr = 1;
      end else begin
        v = (ref_mem[idx] >> (8 * off)) & mask;
        if (!un && nbytes != 4 && v[8 * nbytes - 1]) v = v | ~mask;
        rd = v;
        lat = 2;
      end
    end
  endtask

  task automatic run_req(input string tag, input logic we, input logic [1:0] sz,
                         input logic un, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] x_rd, got_rd;
    logic        x_err, got_err;
    int          x_lat, x_wr, lat, writes, cyc;
    model(we, sz, un, a, wd, x_rd, x_err, x_lat, x_wr);
    @(negedge clk);
    chk({tag, "_ready"}, 32'(req_ready), 1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = un;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    // Scrambled inputs while busy must not matter.
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 0; writes = 0; cyc = 0; got_rd = '0; got_err = 1'b0;
    while (lat == 0 && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (mem_wr_en) writes++;
      if (resp_valid) begin
        lat = cyc; got_rd = resp_rdata; got_err = resp_err;
      end
    end
    chk({tag, "_lat"}, lat, x_lat);
    chk({tag, "_rdata"}, got_rd, x_rd);
    chk({tag, "_err"}, 32'(got_err), 32'(x_err));
    chk({tag, "_writes"}, writes, x_wr);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(resp_valid), 0);
    chk({tag, "_mem"}, mem[a[11:2]], ref_mem[a[11:2]]);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v, hi, rd6;
    logic        e6;
    logic [5:0]  rdy_pat, rv_pat;
    int          l6, w6;
    logic        we;
    logic [1:0]  sz;
    int          r;

    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", 32'(resp_err), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wr_en", 32'(mem_wr_en), 0);
    chk("rst_wr_data", mem_wr_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_req("t1_sw", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    chk("t1_word", mem[4], 32'hDEAD_BEEF);
    run_req("t1_lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

    run_req("t2_sw", 1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344);
    run_req("t2_sb", 1'b1, 2'b00, 1'b0, 32'h12, 32'h1234_56AA);
    chk("t2_word", mem[4], 32'h11AA_3344);
    run_req("t2_lb", 1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
    run_req("t2_lbu", 1'b0, 2'b00, 1'b1, 32'h12, 32'h0);

    run_req("t3_sw", 1'b1, 2'b10, 1'b0, 32'h10, 32'h8001_7FFF);
    run_req("t3_lh_hi", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    run_req("t3_lhu_hi", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    run_req("t3_lh_lo", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0);

    run_req("t4_lw_mis", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
    run_req("t4_sw_mis", 1'b1, 2'b10, 1'b0, 32'h17, 32'hCAFE_F00D);
    run_req("t4_rsv_ld", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    run_req("t4_rsv_st", 1'b1, 2'b11, 1'b0, 32'h10, 32'h5555_5555);

    // Reset during the write cycle of a sub-word store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h15; req_wdata = 32'h0000_0055;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_wr_before", 32'(mem_wr_en), 1);
    rst = 1'b0;
    #1;
    chk("t5_wr_en", 32'(mem_wr_en), 0);
    chk("t5_resp_valid", 32'(resp_valid), 0);
    chk("t5_rdata", resp_rdata, 0);
    chk("t5_err", 32'(resp_err), 0);
    chk("t5_mem_addr", mem_addr, 0);
    chk("t5_wr_data", mem_wr_data, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_ready", 32'(req_ready), 1);
    chk("t5_word", mem[5], ref_mem[5]);

    // Back-to-back loads with req_valid held high.
    model(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd6, e6, l6, w6);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h0;
    rdy_pat = '0; rv_pat = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rdy_pat[k] = req_ready;
      rv_pat[k]  = resp_valid;
      if (resp_valid) chk("t6_rdata", resp_rdata, rd6);
    end
    req_valid = 1'b0;
    chk("t6_ready_pat", 32'(rdy_pat), 32'h24);
    chk("t6_valid_pat", 32'(rv_pat), 32'h12);
    chk("t6_err", 32'(e6), 0);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom);
      r  = int'($urandom_range(0, 9));
      sz = (r == 9) ? 2'b11 : 2'(r % 3);
      hi = $urandom;
      run_req("rnd", we, sz, 1'($urandom),
              {hi[31:12], 6'b0, 6'($urandom_range(0, 63))}, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
